// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// 32-bit integer ALU for the KGP-RISC execute stage. The operation is chosen
// combinationally from `control`. The result and the four status flags are
// registered, so the outputs always reflect the operands and control value
// sampled at the previous rising clock edge.
//
// Optional feature macro: ALU_ROTATE_EN
//   defined   -> code 8 = ROL and code 9 = ROR, both by b[4:0]
//   undefined -> codes 8 and 9 behave like every other unused code
//
// Ports
//   clk            in   1   system clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   a              in  32   operand A, also the shift/rotate source
//   b              in  32   operand B; b[4:0] is the shift/rotate amount
//   control        in   4   operation select
//   result         out 32   registered result
//   zero_flag      out  1   registered, set when result == 0
//   carry_flag     out  1   registered carry, or the last bit shifted out
//   sign_flag      out  1   registered result[31]
//   overflow_flag  out  1   registered signed overflow
// -----------------------------------------------------------------------------
module alu_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       control,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             sign_flag,
    output logic             overflow_flag
);

    logic [4:0]         w_sh;
    logic [32:0]        w_sum;
    logic [32:0]        w_shl;
    logic [32:0]        w_shr;
    logic signed [32:0] w_sra;
    logic [63:0]        w_rot;
    logic [31:0]        w_res;
    logic               w_carry;
    logic               w_ovf;

    logic [31:0]        r_result;
    logic               r_zero;
    logic               r_carry;
    logic               r_sign;
    logic               r_ovf;

    // Operation select: result, carry and overflow for the current inputs.
    always_comb begin
        w_sh    = b[4:0];
        w_sum   = 33'd0;
        w_shl   = 33'd0;
        w_shr   = 33'd0;
        w_sra   = 33'sd0;
        w_rot   = 64'd0;
        w_res   = 32'd0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (control)
            4'd0: begin
                w_sum   = {1'b0, a} + {1'b0, b};
                w_res   = w_sum[31:0];
                w_carry = w_sum[32];
                w_ovf   = (a[31] == b[31]) && (w_sum[31] != a[31]);
            end
            4'd1: begin
                // Carry out of a + ~b + 1 is the "no borrow" indication.
                w_sum   = {1'b0, a} + {1'b0, ~b} + 33'd1;
                w_res   = w_sum[31:0];
                w_carry = w_sum[32];
                w_ovf   = (a[31] != b[31]) && (w_sum[31] != a[31]);
            end
            4'd2: begin
                w_res = a & b;
            end
            4'd3: begin
                w_res = a ^ b;
            end
            4'd4: begin
                // Bit 32 of the widened shift is a[32-sh]; it is 0 for sh == 0.
                w_shl   = {1'b0, a} << w_sh;
                w_res   = w_shl[31:0];
                w_carry = w_shl[32];
            end
            4'd5: begin
                // Bit 0 of the widened shift is a[sh-1]; it is 0 for sh == 0.
                w_shr   = {a, 1'b0} >> w_sh;
                w_res   = w_shr[32:1];
                w_carry = w_shr[0];
            end
            4'd6: begin
                w_sra   = $signed({a, 1'b0}) >>> w_sh;
                w_res   = w_sra[32:1];
                w_carry = w_sra[0];
            end
            4'd7: begin
                // 0 - b: minuend sign is 0, so overflow only for b = 0x80000000.
                w_sum   = {1'b0, 32'd0} + {1'b0, ~b} + 33'd1;
                w_res   = w_sum[31:0];
                w_carry = w_sum[32];
                w_ovf   = b[31] && w_sum[31];
            end
`ifdef ALU_ROTATE_EN
            4'd8: begin
                w_rot = {a, a} << w_sh;
                w_res = w_rot[63:32];
                if (w_sh != 5'd0) begin
                    w_carry = w_rot[32];
                end else begin
                    w_carry = 1'b0;
                end
            end
            4'd9: begin
                w_rot = {a, a} >> w_sh;
                w_res = w_rot[31:0];
                if (w_sh != 5'd0) begin
                    w_carry = w_rot[31];
                end else begin
                    w_carry = 1'b0;
                end
            end
`endif
            default: begin
                w_res   = 32'd0;
                w_carry = 1'b0;
                w_ovf   = 1'b0;
            end
        endcase
    end

    // Output register: captures result and flags on every rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= 32'd0;
            r_zero   <= 1'b1;
            r_carry  <= 1'b0;
            r_sign   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_result <= w_res;
            r_zero   <= (w_res == 32'd0);
            r_carry  <= w_carry;
            r_sign   <= w_res[31];
            r_ovf    <= w_ovf;
        end
    end

    assign result        = r_result;
    assign zero_flag     = r_zero;
    assign carry_flag    = r_carry;
    assign sign_flag     = r_sign;
    assign overflow_flag = r_ovf;

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  control;
    logic [31:0] result;
    logic        zero_flag;
    logic        carry_flag;
    logic        sign_flag;
    logic        overflow_flag;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [31:0] exp_res;
    logic [3:0]  exp_flags;

    alu_core #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .a             (a),
        .b             (b),
        .control       (control),
        .result        (result),
        .zero_flag     (zero_flag),
        .carry_flag    (carry_flag),
        .sign_flag     (sign_flag),
        .overflow_flag (overflow_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour from plain arithmetic; flags returned as {z,c,s,v}.
    function automatic void model(input logic [31:0] ia, input logic [31:0] ib,
                                  input logic [3:0] op,
                                  output logic [31:0] r, output logic [3:0] f);
        int     sh;
        longint sa;
        longint sb;
        longint sv;
        logic   c;
        logic   v;
        sh = int'(ib[4:0]);
        sa = longint'($signed(ib) * 0) + longint'($signed(ia));
        sb = longint'($signed(ib));
        c  = 1'b0;
        v  = 1'b0;
        r  = 32'd0;
        case (op)
            4'd0: begin
                r  = ia + ib;
                c  = (longint'(ia) + longint'(ib)) > 64'sd4294967295;
                sv = sa + sb;
                v  = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
            end
            4'd1: begin
                r  = ia - ib;
                c  = (ia >= ib);
                sv = sa - sb;
                v  = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
            end
            4'd2: r = ia & ib;
            4'd3: r = ia ^ ib;
            4'd4: begin
                r = ia << sh;
                if (sh != 0) c = ia[32 - sh];
            end
            4'd5: begin
                r = ia >> sh;
                if (sh != 0) c = ia[sh - 1];
            end
            4'd6: begin
                r = $signed(ia) >>> sh;
                if (sh != 0) c = ia[sh - 1];
            end
            4'd7: begin
                r  = 32'd0 - ib;
                c  = (ib == 32'd0);
                sv = -sb;
                v  = (sv > 64'sd2147483647);
            end
`ifdef ALU_ROTATE_EN
            4'd8: begin
                r = ia;
                for (int k = 0; k < sh; k++) r = {r[30:0], r[31]};
                if (sh != 0) c = r[0];
            end
            4'd9: begin
                r = ia;
                for (int k = 0; k < sh; k++) r = {r[0], r[31:1]};
                if (sh != 0) c = r[31];
            end
`endif
            default: r = 32'd0;
        endcase
        f = {(r == 32'd0), c, r[31], v};
    endfunction

    // Expected outputs after each edge, or the reset values while rst_n is low.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_res   <= 32'd0;
            exp_flags <= 4'b1000;
        end else begin
            logic [31:0] mr;
            logic [3:0]  mf;
            model(a, b, control, mr, mf);
            exp_res   <= mr;
            exp_flags <= mf;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (result !== exp_res || {zero_flag, carry_flag, sign_flag, overflow_flag} !== exp_flags) begin
                errors++;
                $display("FAIL model_cmp op=%0d a=%h b=%h : got res=%h flags=%b, want res=%h flags=%b",
                         control, a, b, result,
                         {zero_flag, carry_flag, sign_flag, overflow_flag}, exp_res, exp_flags);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] er, input logic [3:0] ef);
        checks++;
        if (result !== er || {zero_flag, carry_flag, sign_flag, overflow_flag} !== ef) begin
            errors++;
            $display("FAIL %s : got res=%h zcsv=%b, want res=%h zcsv=%b", name, result,
                     {zero_flag, carry_flag, sign_flag, overflow_flag}, er, ef);
        end
    endtask

    // Apply inputs just after an edge, then check them one edge later.
    task automatic apply_check(input string name, input logic [3:0] op,
                               input logic [31:0] ia, input logic [31:0] ib,
                               input logic [31:0] er, input logic [3:0] ef);
        @(posedge clk);
        #2;
        control = op;
        a       = ia;
        b       = ib;
        @(posedge clk);
        #1;
        lit(name, er, ef);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hffff_ffff;
            2:       return 32'h8000_0000;
            3:       return 32'h7fff_ffff;
            4:       return 32'(($urandom_range(0, 7)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n   = 1'b1;
        a       = 32'd0;
        b       = 32'd0;
        control = 4'd0;
        #1;
        rst_n = 1'b0;
        #1;
        lit("reset_initial", 32'd0, 4'b1000);
        repeat (2) @(posedge clk);
        #2;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        apply_check("add_overflow", 4'd0, 32'h7fff_ffff, 32'h7fff_ffff, 32'hffff_fffe, 4'b0011);
        apply_check("add_carry",    4'd0, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 4'b0110);
        apply_check("xor",          4'd3, 32'hffa4_7a78, 32'h0fae_ff12, 32'hf00a_856a, 4'b0010);
        apply_check("shll_18",      4'd4, 32'hffaa_aa78, 32'h03a3_3f12, 32'ha9e0_0000, 4'b0010);
        apply_check("shra_22",      4'd6, 32'h00a1_1a78, 32'h03ae_ff36, 32'h0000_0002, 4'b0100);
        apply_check("sub_equal",    4'd1, 32'd5,         32'd5,         32'h0000_0000, 4'b1100);
        apply_check("comp_zero",    4'd7, 32'd0,         32'd0,         32'h0000_0000, 4'b1100);
        apply_check("comp_minint",  4'd7, 32'd0,         32'h8000_0000, 32'h8000_0000, 4'b0011);
        apply_check("shrl_amt0",    4'd5, 32'h8000_0001, 32'hffff_ffe0, 32'h8000_0001, 4'b0010);
        apply_check("unused_15",    4'd15, 32'h1234_5678, 32'h1, 32'h0000_0000, 4'b1000);

        // Mid-run asynchronous reset, then ADD 20 + 10 after release.
        @(posedge clk);
        #2;
        rst_n   = 1'b0;
        control = 4'd0;
        a       = 32'd20;
        b       = 32'd10;
        #1;
        lit("reset_async", 32'd0, 4'b1000);
        @(posedge clk);
        #1;
        lit("reset_held", 32'd0, 4'b1000);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        lit("add_after_reset", 32'd30, 4'b0000);

        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #2;
            control = 4'($urandom_range(0, 15));
            a       = pick_operand();
            b       = pick_operand();
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
